// File: rtl/chunked_magnitude_comparator.sv
// Multi-cycle wide-operand magnitude comparator: scans CHUNK_WIDTH-bit slices MSB-first,
// optionally stopping at the first differing slice, with valid/ready on both sides.
module chunked_magnitude_comparator #(
    parameter int WIDTH       = 64,
    parameter int CHUNK_WIDTH = 16,
    parameter int EARLY_EXIT  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op_sel,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             result,
    output logic             eq_flag,
    output logic             lt_flag,
    output logic             gt_flag,
    output logic             op_err
);
    localparam int NUM_CHUNKS = WIDTH / CHUNK_WIDTH;
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(NUM_CHUNKS - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic             hit_q, hit_d;
    logic             lt_q, lt_d, gt_q, gt_d, eq_q, eq_d;
    logic             res_q, res_d, err_q, err_d;

    logic [NUM_CHUNKS-1:0] chunk_lt, chunk_gt;
    logic                  cur_lt, cur_gt, fin_lt, fin_gt;

    // Operands are stored offset-binary in signed mode, so every slice compare is unsigned.
    for (genvar i = 0; i < NUM_CHUNKS; i++) begin : g_chunk
        assign chunk_lt[i] = a_q[i*CHUNK_WIDTH +: CHUNK_WIDTH] < b_q[i*CHUNK_WIDTH +: CHUNK_WIDTH];
        assign chunk_gt[i] = a_q[i*CHUNK_WIDTH +: CHUNK_WIDTH] > b_q[i*CHUNK_WIDTH +: CHUNK_WIDTH];
    end

    function automatic logic op_result(input logic [2:0] op, input logic eq,
                                       input logic lt, input logic gt);
        case (op)
            3'b000:  op_result = eq;
            3'b001:  op_result = !eq;
            3'b010:  op_result = lt;
            3'b011:  op_result = lt | eq;
            3'b100:  op_result = gt;
            3'b101:  op_result = gt | eq;
            default: op_result = 1'b0;
        endcase
    endfunction

    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = out_valid & res_q;
    assign eq_flag   = out_valid & eq_q;
    assign lt_flag   = out_valid & lt_q;
    assign gt_flag   = out_valid & gt_q;
    assign op_err    = out_valid & err_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hit_d   = hit_q;
        lt_d    = lt_q;
        gt_d    = gt_q;
        eq_d    = eq_q;
        res_d   = res_q;
        err_d   = err_q;
        cur_lt  = chunk_lt[idx_q];
        cur_gt  = chunk_gt[idx_q];
        // Without early exit the first differing slice decides; later slices only burn cycles.
        fin_lt  = hit_q ? lt_q : cur_lt;
        fin_gt  = hit_q ? gt_q : cur_gt;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_d     = signed_mode ? (a ^ MSB_MASK) : a;
                    b_d     = signed_mode ? (b ^ MSB_MASK) : b;
                    op_d    = op_sel;
                    idx_d   = IDX_MAX;
                    hit_d   = 1'b0;
                    lt_d    = 1'b0;
                    gt_d    = 1'b0;
                    eq_d    = 1'b0;
                    state_d = CMP;
                end
            end
            CMP: begin
                if (!hit_q && (cur_lt || cur_gt)) begin
                    hit_d = 1'b1;
                    lt_d  = cur_lt;
                    gt_d  = cur_gt;
                end
                if (idx_q == '0 || (EARLY_EXIT != 0 && (cur_lt || cur_gt))) begin
                    lt_d    = fin_lt;
                    gt_d    = fin_gt;
                    eq_d    = !(fin_lt || fin_gt);
                    res_d   = op_result(op_q, !(fin_lt || fin_gt), fin_lt, fin_gt);
                    err_d   = op_q[2] & op_q[1];
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    idx_d   = IDX_MAX;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= IDX_MAX;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            hit_q   <= 1'b0;
            lt_q    <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            res_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hit_q   <= hit_d;
            lt_q    <= lt_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end
endmodule
